lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly downstream of the execute-stage ALU.
- Takes the ALU result as the effective address, plus store data and access size.
- Runs a req/gnt/rvalid handshake with data memory and holds the pipeline with a stall until the access finishes.
- Returns size-aligned, sign- or zero-extended load data to writeback.

Parameters:
- WIDTH, 32: data and address width. Only 32 is supported.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  the execute-stage op is valid.
- mem_read  input  1  load request from control.
- mem_write  input  1  store request from control.
- funct3  input  3  access size and sign, RV32I encoding.
- addr  input  WIDTH  effective address (ALUout).
- wdata  input  WIDTH  store data (rs2).
- lsu_stall  output  1  holds the upstream pipeline.
- lsu_done  output  1  one-cycle completion pulse.
- load_data  output  WIDTH  extended load result, valid while lsu_done=1.
- lsu_misalign  output  1  misaligned-access pulse (see Optional Feature).
- mem_req  output  1  memory request.
- mem_we  output  1  1 = write.
- mem_addr  output  WIDTH  word-aligned address, addr with [1:0] forced to 00.
- mem_be  output  4  byte enables.
- mem_wdata  output  WIDTH  lane-replicated store data.
- mem_gnt  input  1  request accepted.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  WIDTH  read data.

Behaviour:
- Reset: state=IDLE. All outputs 0: lsu_done, lsu_misalign, load_data, mem_req, mem_we, mem_addr, mem_be, mem_wdata.
- Reset is async. Asserting it mid-access abandons the access.
- Any mem_gnt or mem_rvalid arriving while in IDLE is ignored.
- op = ex_valid & (mem_read | mem_write). If mem_read and mem_write are both high, the access is a load.
- lsu_stall = (state != IDLE) | (op & ~lsu_done). This is combinational.
- The ~lsu_done term stops the op still presented in the done cycle from being re-accepted.
- FSM states: IDLE, REQ, RESP.
  - IDLE: if op & ~lsu_done, latch addr offset, funct3 and load/store. Drive mem_* as registered outputs and go to REQ.
  - REQ: mem_req=1; mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_gnt.
    - Store with gnt: go to IDLE, lsu_done=1 next cycle.
    - Load with gnt and no rvalid: go to RESP.
    - Load with gnt and rvalid in the same cycle: complete directly (go to IDLE, done next cycle).
  - RESP: mem_req=0, wait for mem_rvalid, then go to IDLE with lsu_done=1 next cycle.
- Completion: at the completing edge, lsu_done and load_data are registered. lsu_done=1 for exactly one cycle.
  - load_data keeps its value until the next load completes.
  - For stores, load_data is unchanged.
- Store lanes, off = addr[1:0]:
  - SB (000): be = 0001<<off; wdata byte replicated into all four lanes.
  - SH (001): be = 0011<<off; wdata halfword replicated into both halves.
  - SW (010): be = 1111.
- Load extract:
  - LB / LBU (000 / 100): byte at lane off, sign- / zero-extended.
  - LH / LHU (001 / 101): halfword at lanes off..off+1, sign- / zero-extended.
  - LW (010): full word.
  - Loads drive mem_be = 1111.
- Other funct3 codes are handled as LW / SW.
- Minimum latency, counting the accept cycle as cycle 0:
  - Store: gnt in cycle 1, done in cycle 2.
  - Load: gnt in cycle 1, rvalid in cycle 2, done in cycle 3.
  - With gnt and rvalid both in cycle 1, the load is done in cycle 2.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=00, is misaligned.
  - A misaligned op issues no memory request: IDLE goes straight back to IDLE.
  - lsu_done and lsu_misalign both pulse one cycle after acceptance; load_data is unchanged.
- Undefined:
  - lsu_misalign is tied to 0.
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0].
  - The access proceeds normally and cannot straddle lanes.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt on the first REQ cycle -> mem_addr=0x100, be=1111, mem_we=1; lsu_done in cycle 2; lsu_stall high in cycles 0–1 only.
- LB addr=0x203, rdata=0x80FF_1234, rvalid one cycle after gnt -> load_data=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH addr=0x12, wdata=0x0000ABCD -> mem_addr=0x10, be=1100, wdata=0xABCDABCD. LHU addr=0x12 with rdata=0xABCD0000 -> 0x0000ABCD.
- LW with gnt held low for 3 cycles -> mem_req and mem_addr stable throughout; done exactly once; the op is not reissued during the done cycle.
- Load in RESP, rst_n pulsed low, stale rvalid arrives after reset -> outputs 0, state IDLE, no lsu_done.
- With LSU_MISALIGN_CHECK_EN: LW addr=0x102 -> no mem_req; lsu_done=lsu_misalign=1 in cycle 1. Without it: mem_addr=0x100, normal completion.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: req/gnt/rvalid data-memory handshake, lane steering, load extension.
// Optional LSU_MISALIGN_CHECK_EN traps misaligned halfword/word accesses without a bus request.
module lsu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             lsu_stall,
    output logic             lsu_done,
    output logic [WIDTH-1:0] load_data,
    output logic             lsu_misalign,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    state_t     state;
    logic [1:0] off_q;
    logic [2:0] f3_q;
    logic       load_q;

    logic       op;
    logic       accept;
    size_t      size_in;
    size_t      size_q;
    logic       misaligned;
    logic [3:0] st_be;
    logic [WIDTH-1:0] st_data;
    logic [WIDTH-1:0] ld_ext;

    // Both read and write high resolves to a load.
    assign op     = ex_valid & (mem_read | mem_write);
    assign accept = op & ~lsu_done;

    // The op still presented in the done cycle must not be taken again.
    assign lsu_stall = (state != IDLE) | accept;

    // Access size; unlisted funct3 codes fall back to word.
    function automatic size_t size_of(input logic [2:0] f3, input logic ld);
        size_t s;
        s = SZ_W;
        if (ld) begin
            unique case (f3)
                3'b000, 3'b100: s = SZ_B;
                3'b001, 3'b101: s = SZ_H;
                default:        s = SZ_W;
            endcase
        end else begin
            unique case (f3)
                3'b000:  s = SZ_B;
                3'b001:  s = SZ_H;
                default: s = SZ_W;
            endcase
        end
        return s;
    endfunction

    assign size_in = size_of(funct3, mem_read);
    assign size_q  = size_of(f3_q, load_q);

`ifdef LSU_MISALIGN_CHECK_EN
    logic mis_q;

    // Halfwords need addr[0]=0, words need addr[1:0]=00.
    always_comb begin
        misaligned = 1'b0;
        unique case (size_in)
            SZ_H:    misaligned = addr[0];
            SZ_W:    misaligned = |addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign lsu_misalign = mis_q;
`else
    assign misaligned   = 1'b0;
    assign lsu_misalign = 1'b0;
`endif

    // Store byte enables and lane-replicated store data.
    always_comb begin
        st_be   = 4'b1111;
        st_data = wdata;
        unique case (size_in)
            SZ_B: begin
                st_be   = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            SZ_H: begin
                st_be   = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = wdata;
            end
        endcase
    end

    // Pick the addressed lane(s) of the read word and extend.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        unique case (off_q)
            2'd0:    b = mem_rdata[7:0];
            2'd1:    b = mem_rdata[15:8];
            2'd2:    b = mem_rdata[23:16];
            default: b = mem_rdata[31:24];
        endcase
        h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_ext = mem_rdata;
        unique case (size_q)
            SZ_B:    ld_ext = {{24{b[7] & ~f3_q[2]}}, b};
            SZ_H:    ld_ext = {{16{h[15] & ~f3_q[2]}}, h};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Access FSM with registered bus and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
            load_q    <= 1'b0;
            lsu_done  <= 1'b0;
            load_data <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            lsu_done <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
            mis_q    <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        off_q  <= addr[1:0];
                        f3_q   <= funct3;
                        load_q <= mem_read;
                        if (misaligned) begin
                            lsu_done <= 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
                            mis_q    <= 1'b1;
`endif
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= ~mem_read;
                            mem_addr  <= {addr[WIDTH-1:2], 2'b00};
                            mem_be    <= mem_read ? 4'b1111 : st_be;
                            mem_wdata <= st_data;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (!load_q) begin
                            lsu_done <= 1'b1;
                            state    <= IDLE;
                        end else if (mem_rvalid) begin
                            load_data <= ld_ext;
                            lsu_done  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        load_data <= ld_ext;
                        lsu_done  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stores, loads, stalls, reset abort, misalign.
// Expected values are hand-computed per access.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        lsu_stall, lsu_done, lsu_misalign;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    lsu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .lsu_stall(lsu_stall), .lsu_done(lsu_done),
        .load_data(load_data), .lsu_misalign(lsu_misalign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        ex_valid  = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
    endtask

    task automatic drop();
        ex_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Load with gnt in cycle 1 and rvalid in cycle 2; checks done in cycle 3.
    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] rd,
                           input logic [31:0] exp);
        issue(1'b1, 1'b0, f3, a, 32'h0);
        tick();
        mem_gnt = 1'b1;
        settle();
        chk({tag, "_req"}, {31'b0, mem_req}, 32'd1);
        chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        settle();
        chk({tag, "_resp_stall"}, {31'b0, lsu_stall}, 32'd1);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk({tag, "_done"}, {31'b0, lsu_done}, 32'd1);
        chk({tag, "_data"}, load_data, exp);
        drop();
    endtask

    initial begin
        rst_n = 1'b0;
        drop();
        funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #12;
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_done", {31'b0, lsu_done}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_be", {28'b0, mem_be}, 32'h0);
        chk("rst_ld", load_data, 32'h0);
        chk("rst_mis", {31'b0, lsu_misalign}, 32'd0);
        rst_n = 1'b1;
        tick();

        // SW 0x100, gnt on the first REQ cycle.
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        settle();
        chk("sw_c0_stall", {31'b0, lsu_stall}, 32'd1);
        chk("sw_c0_req", {31'b0, mem_req}, 32'd0);
        tick();
        mem_gnt = 1'b1;
        settle();
        chk("sw_c1_stall", {31'b0, lsu_stall}, 32'd1);
        chk("sw_c1_req", {31'b0, mem_req}, 32'd1);
        chk("sw_we", {31'b0, mem_we}, 32'd1);
        chk("sw_addr", mem_addr, 32'h100);
        chk("sw_be", {28'b0, mem_be}, 32'hF);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        mem_gnt = 1'b0;
        settle();
        chk("sw_c2_done", {31'b0, lsu_done}, 32'd1);
        chk("sw_c2_stall", {31'b0, lsu_stall}, 32'd0);
        chk("sw_c2_req", {31'b0, mem_req}, 32'd0);
        drop();
        tick();
        chk("sw_c3_done", {31'b0, lsu_done}, 32'd0);
        chk("sw_c3_stall", {31'b0, lsu_stall}, 32'd0);

        // LB / LBU lane 3.
        do_load("lb", 3'b000, 32'h203, 32'h80FF1234, 32'hFFFFFF80);
        tick();
        do_load("lbu", 3'b100, 32'h203, 32'h80FF1234, 32'h00000080);
        tick();
        do_load("lh", 3'b001, 32'h10, 32'h12348001, 32'hFFFF8001);
        tick();

        // SH 0x12: upper half lanes, replicated data.
        issue(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000ABCD);
        tick();
        mem_gnt = 1'b1;
        settle();
        chk("sh_addr", mem_addr, 32'h10);
        chk("sh_be", {28'b0, mem_be}, 32'hC);
        chk("sh_wdata", mem_wdata, 32'hABCDABCD);
        tick();
        mem_gnt = 1'b0;
        settle();
        chk("sh_done", {31'b0, lsu_done}, 32'd1);
        chk("sh_ld_kept", load_data, 32'hFFFF8001);
        drop();
        tick();

        // SB 0x101: lane 1 enable, byte replicated.
        issue(1'b0, 1'b1, 3'b000, 32'h101, 32'h1234565A);
        tick();
        mem_gnt = 1'b1;
        settle();
        chk("sb_be", {28'b0, mem_be}, 32'h2);
        chk("sb_wdata", mem_wdata, 32'h5A5A5A5A);
        tick();
        mem_gnt = 1'b0;
        drop();
        tick();

        // LHU 0x12 with gnt and rvalid together: done in cycle 2.
        issue(1'b1, 1'b0, 3'b101, 32'h12, 32'h0);
        tick();
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hABCD0000;
        settle();
        chk("lhu_be", {28'b0, mem_be}, 32'hF);
        chk("lhu_we", {31'b0, mem_we}, 32'd0);
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        settle();
        chk("lhu_done", {31'b0, lsu_done}, 32'd1);
        chk("lhu_data", load_data, 32'h0000ABCD);
        drop();
        tick();

        // LW with gnt held low for three REQ cycles.
        issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lw_wait_req", {31'b0, mem_req}, 32'd1);
            chk("lw_wait_addr", mem_addr, 32'h300);
            chk("lw_wait_done", {31'b0, lsu_done}, 32'd0);
        end
        tick();
        mem_gnt = 1'b1;
        settle();
        chk("lw_gnt_req", {31'b0, mem_req}, 32'd1);
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        settle();
        chk("lw_resp_req", {31'b0, mem_req}, 32'd0);
        chk("lw_resp_done", {31'b0, lsu_done}, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("lw_done", {31'b0, lsu_done}, 32'd1);
        chk("lw_data", load_data, 32'hCAFEF00D);
        chk("lw_done_stall", {31'b0, lsu_stall}, 32'd0);
        tick();
        chk("lw_no_reissue", {31'b0, mem_req}, 32'd0);
        chk("lw_done_once", {31'b0, lsu_done}, 32'd0);
        drop();
        tick();

        // Reset while waiting in RESP, then a stale rvalid.
        issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        drop();
        settle();
        chk("ar_in_resp", {31'b0, lsu_stall}, 32'd1);
        rst_n = 1'b0;
        settle();
        chk("ar_stall", {31'b0, lsu_stall}, 32'd0);
        chk("ar_addr", mem_addr, 32'h0);
        chk("ar_ld", load_data, 32'h0);
        chk("ar_be", {28'b0, mem_be}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55AA55AA;
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("ar_stale_done", {31'b0, lsu_done}, 32'd0);
        chk("ar_stale_ld", load_data, 32'h0);
        tick();
        chk("ar_stale_done2", {31'b0, lsu_done}, 32'd0);
        chk("ar_stale_req", {31'b0, mem_req}, 32'd0);

        // LW to 0x102.
        issue(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        tick();
        drop();
        settle();
        chk("mis_req", {31'b0, mem_req}, 32'd0);
        chk("mis_done", {31'b0, lsu_done}, 32'd1);
        chk("mis_flag", {31'b0, lsu_misalign}, 32'd1);
        chk("mis_ld", load_data, 32'h0);
        tick();
        chk("mis_done_end", {31'b0, lsu_done}, 32'd0);
        chk("mis_flag_end", {31'b0, lsu_misalign}, 32'd0);
`else
        tick();
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BADF00D;
        settle();
        chk("mis_req", {31'b0, mem_req}, 32'd1);
        chk("mis_addr", mem_addr, 32'h100);
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        drop();
        settle();
        chk("mis_done", {31'b0, lsu_done}, 32'd1);
        chk("mis_flag", {31'b0, lsu_misalign}, 32'd0);
        chk("mis_ld", load_data, 32'h0BADF00D);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
